// File: rtl/fir_engine.sv
// fir_engine: 4-tap signed FIR datapath executing start/clear/enable commands from the HWPE control FSM.
// Optional build macro FIR_SATURATE_EN: saturate the shifted sum to the signed DATA_WIDTH range instead of wrapping.
module fir_engine #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         test_mode_i,
    input  logic                         clear_i,
    input  logic                         ctrl_start_i,
    input  logic                         ctrl_clear_i,
    input  logic                         ctrl_enable_i,
    input  logic                         ctrl_simple_mul_i,
    input  logic [4:0]                   ctrl_shift_i,
    input  logic [CNT_WIDTH-1:0]         ctrl_len_i,
    input  logic signed [DATA_WIDTH-1:0] ctrl_coeff0_i,
    input  logic signed [DATA_WIDTH-1:0] ctrl_coeff1_i,
    input  logic signed [DATA_WIDTH-1:0] ctrl_coeff2_i,
    input  logic signed [DATA_WIDTH-1:0] ctrl_coeff3_i,
    output logic                         flag_ready_o,
    output logic [CNT_WIDTH-1:0]         flag_cnt_o,
    output logic                         flag_done_o,
    input  logic                         a_valid_i,
    input  logic signed [DATA_WIDTH-1:0] a_data_i,
    output logic                         a_ready_o,
    output logic                         b_valid_o,
    output logic signed [DATA_WIDTH-1:0] b_data_o,
    input  logic                         b_ready_i
);

    localparam int unsigned PW = 2 * DATA_WIDTH;
    localparam int unsigned SW = 2 * DATA_WIDTH + 2;

`ifdef FIR_SATURATE_EN
    localparam logic signed [SW-1:0] SAT_MAX = (SW'(1) << (DATA_WIDTH - 1)) - SW'(1);
    localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                       r_state;
    logic [CNT_WIDTH-1:0]         r_len;
    logic [CNT_WIDTH-1:0]         r_in_cnt;
    logic [CNT_WIDTH-1:0]         r_cnt;
    logic [4:0]                   r_shift;
    logic                         r_smul;
    logic signed [DATA_WIDTH-1:0] r_c0;
    logic signed [DATA_WIDTH-1:0] r_c1;
    logic signed [DATA_WIDTH-1:0] r_c2;
    logic signed [DATA_WIDTH-1:0] r_c3;
    logic signed [DATA_WIDTH-1:0] r_x1;
    logic signed [DATA_WIDTH-1:0] r_x2;
    logic signed [DATA_WIDTH-1:0] r_x3;
    logic signed [DATA_WIDTH-1:0] r_data_p1;
    logic                         r_vld_p1;

    logic                         w_clear;
    logic                         w_start;
    logic                         w_in_hs;
    logic                         w_out_hs;
    logic                         w_last_out;
    logic signed [PW-1:0]         w_prod0_p0;
    logic signed [PW-1:0]         w_prod1_p0;
    logic signed [PW-1:0]         w_prod2_p0;
    logic signed [PW-1:0]         w_prod3_p0;
    logic signed [SW-1:0]         w_sum_p0;
    logic signed [SW-1:0]         w_shifted_p0;
    logic signed [DATA_WIDTH-1:0] w_y_p0;
    logic                         w_unused;

    // Narrow the shifted sum to DATA_WIDTH: clamp when saturating, otherwise keep the low bits.
    function automatic logic signed [DATA_WIDTH-1:0] f_narrow(input logic signed [SW-1:0] v);
`ifdef FIR_SATURATE_EN
        if (v > SAT_MAX) begin
            f_narrow = SAT_MAX[DATA_WIDTH-1:0];
        end else if (v < SAT_MIN) begin
            f_narrow = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            f_narrow = v[DATA_WIDTH-1:0];
        end
`else
        f_narrow = v[DATA_WIDTH-1:0];
`endif
    endfunction

    assign w_unused   = test_mode_i;
    assign w_clear    = clear_i | ctrl_clear_i;
    assign w_start    = (r_state == S_IDLE) & ctrl_start_i & ctrl_enable_i;
    assign a_ready_o  = ~w_clear & (r_state == S_RUN) & ctrl_enable_i
                      & (r_in_cnt < r_len) & (~r_vld_p1 | b_ready_i);
    assign w_in_hs    = a_valid_i & a_ready_o;
    assign w_out_hs   = r_vld_p1 & b_ready_i;
    assign w_last_out = w_out_hs & ((r_cnt + CNT_WIDTH'(1)) == r_len);

    // Stage p0: full-precision products and sum of the accepted sample and delay line
    assign w_prod0_p0   = PW'(a_data_i) * PW'(r_c0);
    assign w_prod1_p0   = PW'(r_x1) * PW'(r_c1);
    assign w_prod2_p0   = PW'(r_x2) * PW'(r_c2);
    assign w_prod3_p0   = PW'(r_x3) * PW'(r_c3);
    assign w_sum_p0     = r_smul ? SW'(w_prod0_p0)
                                 : SW'(w_prod0_p0) + SW'(w_prod1_p0)
                                   + SW'(w_prod2_p0) + SW'(w_prod3_p0);
    assign w_shifted_p0 = w_sum_p0 >>> r_shift;
    assign w_y_p0       = f_narrow(w_shifted_p0);

    // Stage p1: output register, counters and job state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= S_IDLE;
            r_len     <= '0;
            r_in_cnt  <= '0;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_smul    <= 1'b0;
            r_vld_p1  <= 1'b0;
            r_data_p1 <= '0;
        end else if (w_clear) begin
            r_state   <= S_IDLE;
            r_in_cnt  <= '0;
            r_cnt     <= '0;
            r_vld_p1  <= 1'b0;
            r_data_p1 <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_len    <= ctrl_len_i;
                        r_shift  <= ctrl_shift_i;
                        r_smul   <= ctrl_simple_mul_i;
                        r_in_cnt <= '0;
                        r_cnt    <= '0;
                        r_state  <= (ctrl_len_i == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_in_hs) begin
                        r_in_cnt  <= r_in_cnt + CNT_WIDTH'(1);
                        r_data_p1 <= w_y_p0;
                        r_vld_p1  <= 1'b1;
                    end else if (w_out_hs) begin
                        r_vld_p1  <= 1'b0;
                    end
                    if (w_out_hs) begin
                        r_cnt <= r_cnt + CNT_WIDTH'(1);
                    end
                    if (w_last_out) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Coefficients and delay line: zeroed at start so they need no reset of their own
    always_ff @(posedge clk_i) begin
        if (w_clear) begin
            r_x1 <= '0;
            r_x2 <= '0;
            r_x3 <= '0;
        end else if (w_start) begin
            r_c0 <= ctrl_coeff0_i;
            r_c1 <= ctrl_coeff1_i;
            r_c2 <= ctrl_coeff2_i;
            r_c3 <= ctrl_coeff3_i;
            r_x1 <= '0;
            r_x2 <= '0;
            r_x3 <= '0;
        end else if (w_in_hs) begin
            r_x1 <= a_data_i;
            r_x2 <= r_x1;
            r_x3 <= r_x2;
        end
    end

    assign flag_ready_o = (r_state == S_IDLE);
    assign flag_done_o  = (r_state == S_DONE);
    assign flag_cnt_o   = r_cnt;
    assign b_valid_o    = r_vld_p1;
    assign b_data_o     = r_data_p1;

endmodule

// File: tb/tb_fir_engine.sv
// Self-checking bench for fir_engine: table vectors, hand-written corner sequences and
// randomized jobs compared against a sliding-window FIR reference model.
module tb_fir_engine;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        test_mode_i;
    logic        clear_i;
    logic        ctrl_start_i;
    logic        ctrl_clear_i;
    logic        ctrl_enable_i;
    logic        ctrl_simple_mul_i;
    logic [4:0]  ctrl_shift_i;
    logic [31:0] ctrl_len_i;
    logic [31:0] ctrl_coeff0_i;
    logic [31:0] ctrl_coeff1_i;
    logic [31:0] ctrl_coeff2_i;
    logic [31:0] ctrl_coeff3_i;
    logic        flag_ready_o;
    logic [31:0] flag_cnt_o;
    logic        flag_done_o;
    logic        a_valid_i;
    logic [31:0] a_data_i;
    logic        a_ready_o;
    logic        b_valid_o;
    logic [31:0] b_data_o;
    logic        b_ready_i;

    always #5 clk_i = ~clk_i;

    fir_engine #(.DATA_WIDTH(32), .CNT_WIDTH(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .test_mode_i(test_mode_i), .clear_i(clear_i),
        .ctrl_start_i(ctrl_start_i), .ctrl_clear_i(ctrl_clear_i), .ctrl_enable_i(ctrl_enable_i),
        .ctrl_simple_mul_i(ctrl_simple_mul_i), .ctrl_shift_i(ctrl_shift_i), .ctrl_len_i(ctrl_len_i),
        .ctrl_coeff0_i(ctrl_coeff0_i), .ctrl_coeff1_i(ctrl_coeff1_i),
        .ctrl_coeff2_i(ctrl_coeff2_i), .ctrl_coeff3_i(ctrl_coeff3_i),
        .flag_ready_o(flag_ready_o), .flag_cnt_o(flag_cnt_o), .flag_done_o(flag_done_o),
        .a_valid_i(a_valid_i), .a_data_i(a_data_i), .a_ready_o(a_ready_o),
        .b_valid_o(b_valid_o), .b_data_o(b_data_o), .b_ready_i(b_ready_i)
    );

`ifdef FIR_SATURATE_EN
    localparam logic [31:0] E_POS  = 32'h7FFF_FFFF;
    localparam logic [31:0] E_NEG  = 32'h8000_0000;
    localparam logic [31:0] E_WIDE = 32'h7FFF_FFFF;
`else
    localparam logic [31:0] E_POS  = 32'h0000_0000;
    localparam logic [31:0] E_NEG  = 32'h0000_0000;
    localparam logic [31:0] E_WIDE = 32'hFFFF_FFFC;
`endif

    typedef struct packed {
        logic             smul;
        logic [4:0]       shift;
        logic [7:0]       len;
        logic [0:3][31:0] c;
        logic [0:7][31:0] x;
        logic [0:7][31:0] y;
    } vec_t;

    vec_t        tbl[7];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] xin[64];
    logic [31:0] exp_y[64];
    logic [31:0] got[$];
    logic [31:0] j_c[4];
    logic        j_smul;
    int          j_shift;
    int          j_len;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: y[n] = sum over k of c[k]*x[n-k] (x before the job is zero), then >>> shift.
    function automatic logic [31:0] model_y(input int n);
        logic signed [65:0] acc;
        logic signed [65:0] a;
        logic signed [65:0] b;
        acc = '0;
        for (int k = 0; k < 4; k++) begin
            if (n - k >= 0 && (k == 0 || !j_smul)) begin
                a = $signed(j_c[k]);
                b = $signed(xin[n - k]);
                acc += a * b;
            end
        end
        acc = acc >>> j_shift;
`ifdef FIR_SATURATE_EN
        if (acc > 66'sh7FFF_FFFF) return 32'h7FFF_FFFF;
        if (acc < -66'sh8000_0000) return 32'h8000_0000;
`endif
        return acc[31:0];
    endfunction

    task automatic apply_cfg();
        ctrl_simple_mul_i = j_smul;
        ctrl_shift_i      = 5'(j_shift);
        ctrl_len_i        = 32'(j_len);
        ctrl_coeff0_i     = j_c[0];
        ctrl_coeff1_i     = j_c[1];
        ctrl_coeff2_i     = j_c[2];
        ctrl_coeff3_i     = j_c[3];
    endtask

    task automatic load_vec(input int t);
        j_smul  = tbl[t].smul;
        j_shift = int'(tbl[t].shift);
        j_len   = int'(tbl[t].len);
        for (int k = 0; k < 4; k++) j_c[k] = tbl[t].c[k];
        for (int i = 0; i < 8; i++) begin
            xin[i]   = tbl[t].x[i];
            exp_y[i] = tbl[t].y[i];
        end
    endtask

    // mode 0: always ready/valid; 1: random ready/valid/enable plus noise on start and config;
    // 2: sink stalls 3 cycles on the 2nd output. gap_at: enable low 4 cycles. clr_after: clear after N outputs.
    task automatic run_job(input string tag, input int mode, input int gap_at, input int clr_after);
        int          sent, rcvd, done_cnt, done_cyc, last_hs, stall;
        logic        held_v, br, av, en, ok_end;
        logic [31:0] held;
        got.delete();
        @(negedge clk_i);
        apply_cfg();
        ctrl_start_i = 1'b1; ctrl_enable_i = 1'b1; a_valid_i = 1'b0; b_ready_i = 1'b1;
        @(negedge clk_i);
        ctrl_start_i = 1'b0;
        sent = 0; rcvd = 0; done_cnt = 0; done_cyc = -1; last_hs = -10; stall = 0;
        held_v = 1'b0; held = '0; ok_end = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            en = !(gap_at >= 0 && cyc >= gap_at && cyc < gap_at + 4);
            if (mode == 1) en = ($urandom_range(0, 7) != 0);
            br = 1'b1;
            if (mode == 1) br = ($urandom_range(0, 3) != 0);
            if (mode == 2 && b_valid_o && rcvd == 1 && stall < 3) begin
                br = 1'b0;
                stall++;
            end
            av = (sent < j_len) && (mode != 1 || $urandom_range(0, 1) == 1);
            ctrl_enable_i = en;
            b_ready_i     = br;
            a_valid_i     = av;
            a_data_i      = (sent < j_len) ? xin[sent] : $urandom();
            if (mode == 1) begin
                ctrl_start_i  = (done_cnt == 0) && ($urandom_range(0, 1) == 1);
                ctrl_len_i    = $urandom_range(0, 50);
                ctrl_shift_i  = 5'($urandom_range(0, 31));
                ctrl_coeff0_i = $urandom();
                ctrl_coeff1_i = $urandom();
                ctrl_simple_mul_i = 1'($urandom_range(0, 1));
            end
            #1;
            if (flag_done_o) begin
                done_cnt++;
                done_cyc = cyc;
                check({tag, " done-timing"}, 64'(cyc), 64'(last_hs + 1));
                check({tag, " outputs-at-done"}, 64'(rcvd), 64'(j_len));
            end
            if (held_v) begin
                check({tag, " hold-data"}, 64'(b_data_o), 64'(held));
                check({tag, " hold-valid"}, 64'(b_valid_o), 64'(1));
            end
            if (b_valid_o && !br) check({tag, " a_ready-in-stall"}, 64'(a_ready_o), 64'(0));
            if (!en) check({tag, " a_ready-disabled"}, 64'(a_ready_o), 64'(0));
            if (mode == 0 && gap_at < 0 && sent < j_len && done_cnt == 0)
                check({tag, " a_ready-throughput"}, 64'(a_ready_o), 64'(1));
            if (b_valid_o && br) begin
                got.push_back(b_data_o);
                rcvd++;
                last_hs = cyc;
            end
            held_v = b_valid_o && !br;
            held   = b_data_o;
            if (av && a_ready_o) sent++;
            if (clr_after >= 0 && rcvd == clr_after) break;
            if (done_cnt > 0 && cyc == done_cyc + 1) begin
                ok_end = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
        if (clr_after >= 0) begin
            check({tag, " outputs-before-clear"}, 64'(rcvd), 64'(clr_after));
            for (int i = 0; i < rcvd; i++) check({tag, " pre-clear-data"}, 64'(got[i]), 64'(exp_y[i]));
            @(negedge clk_i);
            a_valid_i = 1'b0; ctrl_clear_i = 1'b1;
            @(negedge clk_i);
            ctrl_clear_i = 1'b0;
            #1;
            check({tag, " clear-ready"}, 64'(flag_ready_o), 64'(1));
            check({tag, " clear-cnt"}, 64'(flag_cnt_o), 64'(0));
            check({tag, " clear-bvalid"}, 64'(b_valid_o), 64'(0));
        end else begin
            check({tag, " finished-in-budget"}, 64'(ok_end), 64'(1));
            check({tag, " ready-after-done"}, 64'(flag_ready_o), 64'(1));
            check({tag, " done-one-cycle"}, 64'(flag_done_o), 64'(0));
            check({tag, " final-cnt"}, 64'(flag_cnt_o), 64'(j_len));
            check({tag, " output-count"}, 64'(got.size()), 64'(j_len));
            for (int i = 0; i < j_len && i < got.size(); i++)
                check({tag, " data"}, 64'(got[i]), 64'(exp_y[i]));
        end
        ctrl_start_i = 1'b0; a_valid_i = 1'b0; ctrl_enable_i = 1'b1; b_ready_i = 1'b1;
    endtask

    initial begin
        tbl[0] = '{smul: 1'b0, shift: 5'd0, len: 8'd6,
                   c: {32'd1, 32'd1, 32'd1, 32'd1},
                   x: {32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd0, 32'd0},
                   y: {32'd1, 32'd3, 32'd6, 32'd10, 32'd14, 32'd18, 32'd0, 32'd0}};
        tbl[1] = '{smul: 1'b1, shift: 5'd1, len: 8'd2,
                   c: {32'd3, 32'd5, 32'd5, 32'd5},
                   x: {32'd4, -32'sd4, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0},
                   y: {32'd6, -32'sd6, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}};
        tbl[2] = '{smul: 1'b0, shift: 5'd0, len: 8'd4,
                   c: {32'd1, 32'd2, 32'd3, 32'd4},
                   x: {32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0},
                   y: {32'd1, 32'd2, 32'd3, 32'd4, 32'd0, 32'd0, 32'd0, 32'd0}};
        tbl[3] = '{smul: 1'b0, shift: 5'd1, len: 8'd2,
                   c: {32'd1, 32'd0, 32'd0, 32'd0},
                   x: {-32'sd3, 32'd5, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0},
                   y: {-32'sd2, 32'd2, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}};
        tbl[4] = '{smul: 1'b1, shift: 5'd0, len: 8'd1,
                   c: {32'h4000_0000, 32'd0, 32'd0, 32'd0},
                   x: {32'd4, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0},
                   y: {E_POS, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}};
        tbl[5] = '{smul: 1'b1, shift: 5'd0, len: 8'd1,
                   c: {32'h4000_0000, 32'd0, 32'd0, 32'd0},
                   x: {-32'sd4, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0},
                   y: {E_NEG, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}};
        tbl[6] = '{smul: 1'b0, shift: 5'd31, len: 8'd2,
                   c: {32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd0, 32'd0},
                   x: {32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0},
                   y: {32'h7FFF_FFFE, E_WIDE, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0}};

        rst_ni = 1'b0; test_mode_i = 1'b0; clear_i = 1'b0; ctrl_start_i = 1'b0;
        ctrl_clear_i = 1'b0; ctrl_enable_i = 1'b0; ctrl_simple_mul_i = 1'b0; ctrl_shift_i = '0;
        ctrl_len_i = '0; ctrl_coeff0_i = '0; ctrl_coeff1_i = '0; ctrl_coeff2_i = '0;
        ctrl_coeff3_i = '0; a_valid_i = 1'b0; a_data_i = '0; b_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        check("reset ready", 64'(flag_ready_o), 64'(1));
        check("reset cnt", 64'(flag_cnt_o), 64'(0));
        check("reset done", 64'(flag_done_o), 64'(0));
        check("reset a_ready", 64'(a_ready_o), 64'(0));
        check("reset b_valid", 64'(b_valid_o), 64'(0));
        check("reset b_data", 64'(b_data_o), 64'(0));
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int t = 0; t < 7; t++) begin
            load_vec(t);
            run_job($sformatf("vec%0d", t), 0, -1, -1);
        end

        load_vec(0);
        run_job("stall", 2, -1, -1);
        load_vec(0);
        run_job("enable-gap", 0, 2, -1);
        load_vec(0);
        run_job("clear", 0, -1, 2);
        load_vec(0);
        run_job("after-clear", 0, -1, -1);

        j_len = 0;
        @(negedge clk_i);
        apply_cfg();
        ctrl_start_i = 1'b1; ctrl_enable_i = 1'b1;
        @(negedge clk_i);
        ctrl_start_i = 1'b0;
        #1;
        check("len0 done", 64'(flag_done_o), 64'(1));
        check("len0 not-ready", 64'(flag_ready_o), 64'(0));
        @(negedge clk_i);
        #1;
        check("len0 done-gone", 64'(flag_done_o), 64'(0));
        check("len0 ready", 64'(flag_ready_o), 64'(1));
        check("len0 cnt", 64'(flag_cnt_o), 64'(0));

        load_vec(0);
        @(negedge clk_i);
        apply_cfg();
        ctrl_start_i = 1'b1; b_ready_i = 1'b1;
        @(negedge clk_i);
        ctrl_start_i = 1'b0; a_valid_i = 1'b1; a_data_i = 32'd7;
        repeat (3) @(negedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        check("midreset ready", 64'(flag_ready_o), 64'(1));
        check("midreset cnt", 64'(flag_cnt_o), 64'(0));
        check("midreset a_ready", 64'(a_ready_o), 64'(0));
        check("midreset b_valid", 64'(b_valid_o), 64'(0));
        check("midreset b_data", 64'(b_data_o), 64'(0));
        a_valid_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        load_vec(0);
        run_job("after-reset", 0, -1, -1);

        for (int r = 0; r < 8; r++) begin
            j_smul  = ($urandom_range(0, 3) == 0);
            j_shift = (r < 4) ? $urandom_range(0, 3) : $urandom_range(0, 31);
            j_len   = $urandom_range(1, 24);
            for (int k = 0; k < 4; k++)
                j_c[k] = (r < 4) ? 32'($urandom_range(0, 20)) - 32'd10 : $urandom();
            for (int i = 0; i < j_len; i++) begin
                xin[i] = (r < 4) ? 32'($urandom_range(0, 200)) - 32'd100 : $urandom();
            end
            for (int i = 0; i < j_len; i++) exp_y[i] = model_y(i);
            run_job($sformatf("rand%0d", r), 1, -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
